// File: rtl/chart_pkg.sv
// Shared types and helpers for the chart sequencer: state encoding, the
// all-zero end-of-chart marker and slicing of {lanes, delay} ROM entries.
package chart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIRE  = 3'd4,
    ST_DONE  = 3'd5
  } chart_state_e;

  // Entries are zero-extended to this width before slicing.
  localparam int ENTRY_MAX_W = 64;
  localparam logic [ENTRY_MAX_W-1:0] END_MARKER = {ENTRY_MAX_W{1'b0}};

  function automatic logic [ENTRY_MAX_W-1:0] entry_lanes(
    input logic [ENTRY_MAX_W-1:0] entry,
    input int                     time_w
  );
    return entry >> time_w;
  endfunction

  function automatic logic [ENTRY_MAX_W-1:0] entry_delay(
    input logic [ENTRY_MAX_W-1:0] entry,
    input int                     time_w
  );
    return entry & ((ENTRY_MAX_W'(1) << time_w) - ENTRY_MAX_W'(1));
  endfunction

  function automatic logic is_end_marker(input logic [ENTRY_MAX_W-1:0] entry);
    return entry == END_MARKER;
  endfunction

endpackage

// File: rtl/counter_up.sv
// Generic up-counter with synchronous clear; used as the chart ROM address.
module counter_up #(
  parameter int WIDTH_P = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  output logic [WIDTH_P-1:0] count_o
);

  logic [WIDTH_P-1:0] count_r;

  // Count register: clear dominates increment.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= {WIDTH_P{1'b0}};
    end else if (up_i) begin
      count_r <= count_r + WIDTH_P'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/chart_sequencer.sv
// Chart sequencer: walks a chart ROM, waits each entry's beat delay and
// presents the entry's lane mask to the arrow spawner over valid/ready.
module chart_sequencer
  import chart_pkg::*;
#(
  parameter int LANES_P  = 4,
  parameter int TIME_W_P = 4,
  parameter int DEPTH_P  = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         loop_i,
  input  logic                         tick_i,
  output logic [$clog2(DEPTH_P)-1:0]   rd_addr_o,
  input  logic [LANES_P+TIME_W_P-1:0]  rd_data_i,
  output logic                         launch_valid_o,
  input  logic                         launch_ready_i,
  output logic [LANES_P-1:0]           launch_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int ADDR_W_LP = $clog2(DEPTH_P);

  chart_state_e          state_r, state_n;
  logic [LANES_P-1:0]    lanes_r, lanes_n;
  logic [TIME_W_P-1:0]   delay_r, delay_n;
  logic                  launch_valid_r;
  logic [LANES_P-1:0]    launch_r;
  logic                  busy_r;
  logic                  done_r;

  logic [ADDR_W_LP-1:0]  addr_s;
  logic                  addr_clr_s;
  logic                  addr_up_s;
  logic                  addr_rst_s;
  logic                  last_s;

  logic [ENTRY_MAX_W-1:0] entry_s;
  logic [LANES_P-1:0]     rd_lanes_s;
  logic [TIME_W_P-1:0]    rd_delay_s;
  logic                   rd_end_s;

  assign entry_s    = ENTRY_MAX_W'(rd_data_i);
  assign rd_lanes_s = LANES_P'(entry_lanes(entry_s, TIME_W_P));
  assign rd_delay_s = TIME_W_P'(entry_delay(entry_s, TIME_W_P));
  assign rd_end_s   = is_end_marker(entry_s);
  assign last_s     = (addr_s == ADDR_W_LP'(DEPTH_P - 1));
  assign addr_rst_s = reset_i | addr_clr_s;

  counter_up #(
    .WIDTH_P (ADDR_W_LP)
  ) u_addr_cnt (
    .clk_i   (clk_i),
    .reset_i (addr_rst_s),
    .up_i    (addr_up_s),
    .count_o (addr_s)
  );

  // Next-state, entry capture and address control; stop overrides everything.
  always_comb begin
    state_n    = state_r;
    lanes_n    = lanes_r;
    delay_n    = delay_r;
    addr_clr_s = 1'b0;
    addr_up_s  = 1'b0;
    if (stop_i) begin
      state_n    = ST_IDLE;
      addr_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_n    = ST_FETCH;
            addr_clr_s = 1'b1;
          end else begin
            state_n = state_r;
          end
        end
        ST_FETCH: begin
          state_n = ST_LOAD;
        end
        ST_LOAD: begin
          lanes_n = rd_lanes_s;
          delay_n = rd_delay_s;
          if (rd_end_s) begin
            if (loop_i) begin
              state_n    = ST_FETCH;
              addr_clr_s = 1'b1;
            end else begin
              state_n = ST_DONE;
            end
          end else if (rd_delay_s == {TIME_W_P{1'b0}}) begin
            state_n = ST_FIRE;
          end else begin
            state_n = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tick_i) begin
            delay_n = delay_r - TIME_W_P'(1);
            if (delay_r == TIME_W_P'(1)) begin
              state_n = ST_FIRE;
            end else begin
              state_n = ST_WAIT;
            end
          end else begin
            state_n = ST_WAIT;
          end
        end
        ST_FIRE: begin
          if (launch_ready_i) begin
            state_n = ST_FETCH;
            if (last_s) begin
              if (loop_i) begin
                addr_clr_s = 1'b1;
              end else begin
                state_n = ST_DONE;
              end
            end else begin
              addr_up_s = 1'b1;
            end
          end else begin
            state_n = ST_FIRE;
          end
        end
        default: begin
          state_n    = ST_IDLE;
          addr_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State, entry and output registers; outputs follow the state being entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= ST_IDLE;
      lanes_r        <= {LANES_P{1'b0}};
      delay_r        <= {TIME_W_P{1'b0}};
      launch_valid_r <= 1'b0;
      launch_r       <= {LANES_P{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_n;
      lanes_r        <= lanes_n;
      delay_r        <= delay_n;
      launch_valid_r <= (state_n == ST_FIRE);
      launch_r       <= (state_n == ST_FIRE) ? lanes_n : {LANES_P{1'b0}};
      busy_r         <= !((state_n == ST_IDLE) || (state_n == ST_DONE));
      done_r         <= (state_n == ST_DONE);
    end
  end

  assign rd_addr_o      = addr_s;
  assign launch_valid_o = launch_valid_r;
  assign launch_o       = launch_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;

endmodule

// File: tb/tb_chart_sequencer.sv
// Randomised bench for chart_sequencer against a timing-rule reference model,
// plus a directed rest-entry check on a 6-lane / 16-deep instance.
module tb_chart_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i = 1'b1, start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0;
  logic       tick_i = 1'b0, launch_ready_i = 1'b0;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       launch_valid, busy, done;
  logic [3:0] launch;
  logic [7:0] rom_mem [8];

  always @(posedge clk) rd_data <= rom_mem[rd_addr];

  chart_sequencer #(.LANES_P(4), .TIME_W_P(4), .DEPTH_P(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .tick_i(tick_i), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .launch_valid_o(launch_valid), .launch_ready_i(launch_ready_i),
    .launch_o(launch), .busy_o(busy), .done_o(done)
  );

  logic       b_start = 1'b0, b_tick = 1'b0, b_ready = 1'b0;
  logic [3:0] b_addr;
  logic [8:0] b_rd_data;
  logic       b_valid, b_busy, b_done;
  logic [5:0] b_launch;
  logic [8:0] b_rom [16];

  always @(posedge clk) b_rd_data <= b_rom[b_addr];

  chart_sequencer #(.LANES_P(6), .TIME_W_P(3), .DEPTH_P(16)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .start_i(b_start), .stop_i(1'b0),
    .loop_i(1'b0), .tick_i(b_tick), .rd_addr_o(b_addr), .rd_data_i(b_rd_data),
    .launch_valid_o(b_valid), .launch_ready_i(b_ready),
    .launch_o(b_launch), .busy_o(b_busy), .done_o(b_done)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: which entry is current, when its wait window opens,
  // how many ticks it has seen, and when it fires / the chart ends.
  int cyc = 0, mp = 0, ws = 0, cnt = 0, fire_at = -1, done_at = -1;
  bit m_active = 1'b0, m_loop = 1'b0;
  int tick_period = 0, tick_pct = 40, ready_pct = 100;

  task automatic enter_entry();
    int guard;
    guard = 0;
    while (rom_mem[mp] == 8'h00 && done_at < 0 && guard < 20) begin
      guard++;
      if (m_loop) begin
        mp = 0;
        ws = ws + 2;
      end else begin
        done_at = ws;
      end
    end
    if (done_at < 0) begin
      cnt     = 0;
      fire_at = (rom_mem[mp][3:0] == 4'd0) ? ws : -1;
    end
  endtask

  // One clock: check outputs, drive inputs (tk/rd: 0/1 forced, 2 = policy), update model.
  task automatic run_cycle(input bit st, input bit sp, input int tk, input int rd);
    bit exp_valid, exp_done, exp_busy, t, r;
    @(negedge clk);
    cyc++;
    exp_done  = m_active && done_at >= 0 && cyc >= done_at;
    exp_valid = m_active && done_at < 0 && fire_at >= 0 && cyc >= fire_at;
    exp_busy  = m_active && !exp_done;
    chk("valid", 32'(launch_valid), 32'(exp_valid));
    chk("mask", 32'(launch), exp_valid ? 32'(rom_mem[mp][7:4]) : 32'd0);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (exp_valid) chk("fire_addr", 32'(rd_addr), 32'(mp));
    if (!m_active) chk("idle_addr", 32'(rd_addr), 32'd0);
    if (tk == 2) t = (tick_period > 0) ? ((cyc % tick_period) == 0) : ($urandom_range(99) < tick_pct);
    else         t = (tk != 0);
    if (rd == 2) r = ($urandom_range(99) < ready_pct);
    else         r = (rd != 0);
    start_i = st; stop_i = sp; tick_i = t; launch_ready_i = r; loop_i = m_loop;
    if (sp) begin
      m_active = 1'b0; done_at = -1; fire_at = -1;
    end else begin
      if (m_active && done_at < 0 && fire_at < 0 && cyc >= ws && t) begin
        cnt++;
        if (cnt == int'(rom_mem[mp][3:0])) fire_at = cyc + 1;
      end
      if (exp_valid && r) begin
        fire_at = -1;
        if (mp == 7) begin
          if (m_loop) mp = 0;
          else done_at = cyc + 1;
        end else begin
          mp++;
        end
        if (done_at < 0) begin
          ws = cyc + 3;
          enter_entry();
        end
      end
      if (st && (!m_active || exp_done)) begin
        m_active = 1'b1; mp = 0; done_at = -1; ws = cyc + 3;
        enter_entry();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; tick_i = 1'b0;
    m_active = 1'b0; done_at = -1; fire_at = -1;
    @(negedge clk);
    cyc++;
    chk("rst_valid", 32'(launch_valid), 32'd0);
    chk("rst_mask", 32'(launch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    reset_i = 1'b0;
  endtask

  task automatic random_chart(input bit with_end);
    for (int i = 0; i < 8; i++) begin
      if (with_end && i != 0 && $urandom_range(99) < 20) begin
        rom_mem[i] = 8'h00;
      end else begin
        rom_mem[i] = {4'($urandom_range(15)), 4'($urandom_range(3))};
        if (rom_mem[i] == 8'h00) rom_mem[i] = 8'h81;
      end
    end
  endtask

  initial begin
    int got_fire, v1, v2, dn;
    logic [5:0] m0, m1;
    logic [3:0] a1;
    for (int i = 0; i < 8; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) b_rom[i] = 9'h000;
    do_reset();

    // Basic chart: tick every 4 cycles, always ready, no loop.
    rom_mem[0] = 8'h12; rom_mem[1] = 8'h60; rom_mem[2] = 8'h00;
    m_loop = 1'b0; tick_period = 4; ready_pct = 100;
    run_cycle(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b0, 2, 2);

    // Same chart under backpressure.
    ready_pct = 15;
    run_cycle(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 80; i++) run_cycle(1'b0, 1'b0, 2, 2);

    // Full 8-entry chart without end marker, looping then finishing.
    random_chart(1'b0);
    m_loop = 1'b1; tick_period = 0; tick_pct = 50; ready_pct = 70;
    run_cycle(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 200; i++) run_cycle(1'b0, 1'b0, 2, 2);
    m_loop = 1'b0;
    for (int i = 0; i < 150; i++) run_cycle(1'b0, 1'b0, 2, 2);
    chk("chart_finished", 32'(done), 32'd1);

    // Stop in WAIT with three ticks still pending, then replay.
    run_cycle(1'b0, 1'b1, 0, 1);
    rom_mem[0] = 8'h15; rom_mem[1] = 8'h20; rom_mem[2] = 8'h00;
    run_cycle(1'b1, 1'b0, 0, 1);
    run_cycle(1'b0, 1'b0, 0, 1);
    run_cycle(1'b0, 1'b0, 0, 1);
    run_cycle(1'b0, 1'b0, 1, 1);
    run_cycle(1'b0, 1'b0, 1, 1);
    run_cycle(1'b0, 1'b1, 1, 1);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 1, 1);
    tick_period = 2; ready_pct = 100;
    run_cycle(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b0, 2, 2);

    // Start and stop together in IDLE: stop wins.
    do_reset();
    run_cycle(1'b1, 1'b1, 0, 1);
    run_cycle(1'b0, 1'b0, 0, 1);
    run_cycle(1'b0, 1'b0, 0, 1);

    // Reset while a mask is being presented.
    run_cycle(1'b1, 1'b0, 1, 0);
    got_fire = 0;
    for (int i = 0; i < 60 && got_fire == 0; i++) begin
      run_cycle(1'b0, 1'b0, 1, 0);
      if (launch_valid) got_fire = 1;
    end
    chk("reach_fire", 32'(got_fire), 32'd1);
    do_reset();

    // Randomised charts, loop modes, starts, stops and backpressure.
    tick_period = 0;
    for (int rnd = 0; rnd < 12; rnd++) begin
      run_cycle(1'b0, 1'b1, 0, 0);
      random_chart(1'b1);
      m_loop = 1'($urandom_range(1));
      tick_pct = $urandom_range(20, 90);
      ready_pct = $urandom_range(20, 100);
      run_cycle(1'b1, 1'b0, 2, 2);
      for (int i = 0; i < 300; i++)
        run_cycle($urandom_range(19) == 0, $urandom_range(249) == 0, 2, 2);
    end
    run_cycle(1'b0, 1'b1, 0, 0);

    // Wide instance: rest entry {0,d3}, then {101101,d1}, then end marker.
    b_rom[0] = {6'b000000, 3'd3};
    b_rom[1] = {6'b101101, 3'd1};
    b_rom[2] = 9'h000;
    @(negedge clk);
    b_start = 1'b1; b_tick = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    v1 = -1; v2 = -1; dn = -1; m0 = 6'h3f; m1 = 6'h00; a1 = 4'hf;
    for (int i = 1; i <= 20; i++) begin
      if (b_valid && v1 < 0) begin
        v1 = i; m0 = b_launch;
      end else if (b_valid && v2 < 0) begin
        v2 = i; m1 = b_launch; a1 = b_addr;
      end
      if (b_done && dn < 0) dn = i;
      @(negedge clk);
    end
    chk("rest_fire_cycle", 32'(v1), 32'd6);
    chk("rest_mask", 32'(m0), 32'd0);
    chk("next_fire_cycle", 32'(v2), 32'd10);
    chk("next_mask", 32'(m1), 32'h2d);
    chk("next_addr", 32'(a1), 32'd1);
    chk("wide_done_cycle", 32'(dn), 32'd13);
    chk("wide_busy_end", 32'(b_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/chart_sequencer.md
Name: chart_sequencer

Overview:
Parametrised successor to the fixed 4-lane chart player. It walks a chart ROM, waits a per-entry number of beat ticks, then presents the entry's lane mask to the arrow spawner over a valid/ready handshake. Added over the old block: configurable lane count, timing width and depth, a start/stop control FSM, an end-of-chart marker, loop mode and backpressure. It sits between the chart ROM (synchronous, 1-cycle read latency) and the arrow-launch logic.

Parameters:
LANES_P, 4, number of arrow lanes (width of lane mask)
TIME_W_P, 4, width of per-entry delay field in beat ticks
DEPTH_P, 8, chart entries; address width = $clog2(DEPTH_P), min 2

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
start_i  in  1  begin playback from address 0 (ignored while busy)
stop_i  in  1  abort playback, return to IDLE
loop_i  in  1  sampled at chart end: 1 = wrap to entry 0, 0 = finish
tick_i  in  1  one-cycle beat strobe
rd_addr_o  out  $clog2(DEPTH_P)  chart ROM read address
rd_data_i  in  LANES_P+TIME_W_P  ROM data {lanes, delay}, valid 1 cycle after rd_addr_o
launch_valid_o  out  1  lane mask valid
launch_ready_i  in  1  spawner accepts mask
launch_o  out  LANES_P  lanes to launch
busy_o  out  1  high in any state but IDLE/DONE
done_o  out  1  high in DONE

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE, rd_addr_o=0, launch_valid_o=0, launch_o=0, busy_o=0, done_o=0, delay counter=0.
- States: IDLE, FETCH, LOAD, WAIT, FIRE, DONE.
- IDLE/DONE: start_i -> FETCH, addr=0. start_i ignored in other states.
- FETCH: rd_addr_o stable; next cycle -> LOAD (covers 1-cycle ROM latency).
- LOAD: register lanes and delay from rd_data_i. End marker = lanes==0 AND delay==0: if loop_i -> FETCH with addr=0, else -> DONE. Otherwise delay==0 -> FIRE, else counter=delay -> WAIT.
- WAIT: each tick_i decrements counter; the tick that takes counter 1->0 moves to FIRE next cycle. Ticks in any other state are ignored (not queued).
- FIRE: launch_valid_o=1, launch_o=registered lanes, both held stable until launch_ready_i. On handshake: if addr==DEPTH_P-1 -> (loop_i ? addr=0 : DONE) else addr+1; then FETCH. launch_o returns to 0 when valid drops.
- lanes==0 with delay!=0 is a rest: waits, then FIRE presents a zero mask (handshake still required).
- Minimum per-entry latency with delay 0 and ready held high: FETCH, LOAD, FIRE = 3 cycles per entry.
- stop_i in any state -> IDLE next cycle, addr=0, valid dropped without handshake. stop_i and start_i together: stop wins.
- reset_i mid-playback: same as reset state; no partial launch.
- Address never exceeds DEPTH_P-1; wrap is explicit, not modular overflow.

Decomposition:
- Shared package chart_pkg: state enum, END_MARKER constant (all-zero entry), field-slicing helpers for {lanes, delay}.
- Reuse the existing counter_up for the ROM address (up_i = handshake, reset_i = stop/restart) and the existing rom as the test memory. The delay down-counter stays inline; no further sub-modules.

Test Plan:
- Chart {4'b0001,d2},{4'b0110,d0},END; start, tick every 4 cycles, ready=1 -> mask 0001 after 2nd tick, then 0110 3 cycles later, then done_o=1, busy_o=0.
- Same chart, launch_ready_i low 5 cycles during FIRE -> launch_o=0001 held 5+ cycles, rd_addr_o unchanged until accept.
- 8-entry chart with no END, loop_i=1 -> after entry 7, rd_addr_o=0 and the sequence repeats; with loop_i=0 -> DONE after entry 7.
- stop_i asserted in WAIT with counter=3 -> IDLE next cycle, launch_valid_o never rises; start_i then replays from address 0.
- start_i and stop_i together in IDLE -> stays IDLE; reset_i in FIRE -> all outputs 0 the following cycle.
- LANES_P=6, TIME_W_P=3, DEPTH_P=16 with rest entry {0,d3} -> zero mask presented after 3 ticks, next entry fetched normally.
